wb_regfile: RTL and testbench

Write-back stage and architectural register file of the 5-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects write-back data (memory vs. ALU result), and commits it to a 32×32-bit register file on the clock edge. Serves the decode stage's two combinational read ports, with optional same-cycle write bypass, and keeps a retired-write counter for debug and performance checks.

---
 rtl/wb_regfile.sv | 115 +++++++++++
 tb/tb_wb_regfile.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Write-back stage and architectural register file (32 x 32-bit) of the
// 5-stage pipeline. Selects write-back data (memory load vs. ALU result),
// commits it to the register file on the rising clock edge, serves the two
// combinational decode read ports and counts retired register writes.
//
// Build option:
//   WB_BYPASS_EN  defined   -> a read of the register being written in the
//                              same cycle returns WBData (write-before-read).
//                 undefined -> reads always return the stored value; the new
//                              value becomes visible after the clock edge.
//
// Ports:
//   clock       in   1   pipeline clock, rising-edge active
//   rst         in   1   asynchronous active-low reset
//   WBreg       in   2   [1] RegWrite, [0] MemtoReg (from MEM/WB)
//   Memreg      in  32   memory load data (from MEM/WB)
//   ALUreg      in  32   ALU result (from MEM/WB)
//   RegRDreg    in   5   destination register index (from MEM/WB)
//   RA1, RA2    in   5   decode read addresses
//   RD1, RD2    out 32   decode read data (combinational)
//   WBData      out 32   selected write-back data (combinational)
//   retire_cnt  out 32   number of committed register writes (wraps)
// -----------------------------------------------------------------------------
module wb_regfile (
  input  logic        clock,
  input  logic        rst,
  input  logic [1:0]  WBreg,
  input  logic [31:0] Memreg,
  input  logic [31:0] ALUreg,
  input  logic [4:0]  RegRDreg,
  input  logic [4:0]  RA1,
  input  logic [4:0]  RA2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WBData,
  output logic [31:0] retire_cnt
);

  // Entry 0 exists for simple indexing but is never written; reads of
  // index 0 are forced to zero in the read logic.
  logic [31:0] regs_r [32];
  logic [31:0] retire_cnt_r;
  logic [31:0] wbdata_s;
  logic        we_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;

  // Write-back data select; held at zero while reset is asserted.
  always_comb begin
    wbdata_s = 32'd0;
    if (!rst) begin
      wbdata_s = 32'd0;
    end else if (WBreg[0]) begin
      wbdata_s = Memreg;
    end else begin
      wbdata_s = ALUreg;
    end
  end

  // Writes to r0 are dropped (and not counted); no writes during reset.
  assign we_s = WBreg[1] && (RegRDreg != 5'd0) && rst;

  // Register file commit and retired-write counter.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
      retire_cnt_r <= 32'd0;
    end else if (we_s) begin
      regs_r[RegRDreg] <= wbdata_s;
      retire_cnt_r     <= retire_cnt_r + 32'd1;
    end
  end

  // Read port 1: r0 reads zero; optional same-cycle bypass from write-back.
  always_comb begin
    rd1_s = 32'd0;
    if (!rst) begin
      rd1_s = 32'd0;
    end else if (RA1 == 5'd0) begin
      rd1_s = 32'd0;
`ifdef WB_BYPASS_EN
    end else if (we_s && (RA1 == RegRDreg)) begin
      rd1_s = wbdata_s;
`endif
    end else begin
      rd1_s = regs_r[RA1];
    end
  end

  // Read port 2: identical behaviour to port 1.
  always_comb begin
    rd2_s = 32'd0;
    if (!rst) begin
      rd2_s = 32'd0;
    end else if (RA2 == 5'd0) begin
      rd2_s = 32'd0;
`ifdef WB_BYPASS_EN
    end else if (we_s && (RA2 == RegRDreg)) begin
      rd2_s = wbdata_s;
`endif
    end else begin
      rd2_s = regs_r[RA2];
    end
  end

  assign RD1        = rd1_s;
  assign RD2        = rd2_s;
  assign WBData     = wbdata_s;
  assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Scoreboard bench for wb_regfile: the stimulus process queues expected
// values (hand-computed) for a sample point and signals the monitor, which
// pops each entry and compares it with the selected DUT output.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clock;
  logic        rst;
  logic [1:0]  WBreg;
  logic [31:0] Memreg;
  logic [31:0] ALUreg;
  logic [4:0]  RegRDreg;
  logic [4:0]  RA1;
  logic [4:0]  RA2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] WBData;
  logic [31:0] retire_cnt;

  wb_regfile dut (
    .clock      (clock),
    .rst        (rst),
    .WBreg      (WBreg),
    .Memreg     (Memreg),
    .ALUreg     (ALUreg),
    .RegRDreg   (RegRDreg),
    .RA1        (RA1),
    .RA2        (RA2),
    .RD1        (RD1),
    .RD2        (RD2),
    .WBData     (WBData),
    .retire_cnt (retire_cnt)
  );

  localparam int SEL_RD1 = 0;
  localparam int SEL_RD2 = 1;
  localparam int SEL_WBD = 2;
  localparam int SEL_CNT = 3;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  event     push_ev;
  int       checks = 0;
  int       errors = 0;

  // Clock generation: period 10, rising edges at 5, 15, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: drain the scoreboard each time a sample point is announced.
  initial begin
    sb_item_t    it;
    logic [31:0] act;
    forever begin
      @(push_ev);
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        case (it.sel)
          SEL_RD1: act = RD1;
          SEL_RD2: act = RD2;
          SEL_WBD: act = WBData;
          default: act = retire_cnt;
        endcase
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic sb_push(input string name, input int sel, input logic [31:0] exp);
    sb_item_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  // Announce a sample point and move off it.
  task automatic sample();
    ->push_ev;
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] rd);
    WBreg    = wb;
    Memreg   = mem;
    ALUreg   = alu;
    RegRDreg = rd;
  endtask

  // Let one rising edge commit, then drop RegWrite.
  task automatic tick();
    @(posedge clock);
    #1;
    WBreg = 2'b00;
  endtask

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] byp_old;
    rst = 1'b0;
    RA1 = 5'd5;
    RA2 = 5'd5;
    drive(2'b10, 32'h0, 32'h1234, 5'd5);
    #1;
    // Reset held across edges: nothing written, all outputs zero.
    repeat (2) @(posedge clock);
    #1;
    sb_push("rst_rd1", SEL_RD1, 32'h0);
    sb_push("rst_rd2", SEL_RD2, 32'h0);
    sb_push("rst_wbdata", SEL_WBD, 32'h0);
    sb_push("rst_cnt", SEL_CNT, 32'h0);
    sample();

    @(negedge clock);
    WBreg = 2'b00;
    rst   = 1'b1;
    #1;
    sb_push("rel_rd1_r5", SEL_RD1, 32'h0);
    sb_push("rel_cnt", SEL_CNT, 32'h0);
    sample();

    // Memory path write to r7.
    RA1 = 5'd7;
    drive(2'b11, 32'hDEAD_BEEF, 32'h11, 5'd7);
    #1;
    sb_push("mux_mem_wbdata", SEL_WBD, 32'hDEAD_BEEF);
`ifdef WB_BYPASS_EN
    sb_push("r7_pre", SEL_RD1, 32'hDEAD_BEEF);
`else
    sb_push("r7_pre", SEL_RD1, 32'h0);
`endif
    sample();
    tick();
    sb_push("r7_post", SEL_RD1, 32'hDEAD_BEEF);
    sb_push("cnt_1", SEL_CNT, 32'd1);
    sample();

    // ALU path write to r8.
    RA2 = 5'd8;
    drive(2'b10, 32'hDEAD_BEEF, 32'h55, 5'd8);
    #1;
    sb_push("mux_alu_wbdata", SEL_WBD, 32'h55);
    sample();
    tick();
    sb_push("r8_post", SEL_RD2, 32'h55);
    sb_push("r7_keep", SEL_RD1, 32'hDEAD_BEEF);
    sb_push("cnt_2", SEL_CNT, 32'd2);
    sample();

    // No RegWrite: WBData still follows the mux, nothing committed.
    drive(2'b00, 32'h0, 32'h77, 5'd8);
    #1;
    sb_push("nowr_wbdata", SEL_WBD, 32'h77);
    sample();
    tick();
    sb_push("nowr_r8", SEL_RD2, 32'h55);
    sb_push("nowr_cnt", SEL_CNT, 32'd2);
    sample();

    // Writes to r0 are ignored and not counted.
    RA1 = 5'd0;
    drive(2'b10, 32'h0, 32'hFFFF, 5'd0);
    #1;
    sb_push("r0_pre", SEL_RD1, 32'h0);
    sb_push("r0_wbdata", SEL_WBD, 32'hFFFF);
    sample();
    tick();
    sb_push("r0_post", SEL_RD1, 32'h0);
    sb_push("r0_cnt", SEL_CNT, 32'd2);
    sample();

    // Same-cycle read of the register being written.
    RA1 = 5'd3;
    RA2 = 5'd3;
    drive(2'b10, 32'h0, 32'hA, 5'd3);
    tick();
    sb_push("r3_a", SEL_RD1, 32'hA);
    sb_push("cnt_3", SEL_CNT, 32'd3);
    sample();
    drive(2'b10, 32'h0, 32'hB, 5'd3);
    #1;
`ifdef WB_BYPASS_EN
    byp_old = 32'hB;
`else
    byp_old = 32'hA;
`endif
    sb_push("byp_rd1_pre", SEL_RD1, byp_old);
    sb_push("byp_rd2_pre", SEL_RD2, byp_old);
    sample();
    tick();
    sb_push("byp_rd1_post", SEL_RD1, 32'hB);
    sb_push("byp_rd2_post", SEL_RD2, 32'hB);
    sb_push("cnt_4", SEL_CNT, 32'd4);
    sample();

    // Asynchronous reset between edges.
    RA1 = 5'd9;
    RA2 = 5'd7;
    drive(2'b10, 32'h0, 32'h99, 5'd9);
    tick();
    sb_push("r9_99", SEL_RD1, 32'h99);
    sb_push("cnt_5", SEL_CNT, 32'd5);
    sample();
    drive(2'b11, 32'h5, 32'h6, 5'd9);
    #1;
    rst = 1'b0;
    #1;
    sb_push("arst_rd1", SEL_RD1, 32'h0);
    sb_push("arst_rd2", SEL_RD2, 32'h0);
    sb_push("arst_wbdata", SEL_WBD, 32'h0);
    sb_push("arst_cnt", SEL_CNT, 32'h0);
    sample();
    WBreg = 2'b00;
    @(negedge clock);
    rst = 1'b1;
    drive(2'b10, 32'h0, 32'h1, 5'd9);
    tick();
    sb_push("rel_r9_1", SEL_RD1, 32'h1);
    sb_push("rel_r7_clr", SEL_RD2, 32'h0);
    sb_push("rel_cnt_1", SEL_CNT, 32'd1);
    sample();

    // Counter wrap via deposit.
    dut.retire_cnt_r <= 32'hFFFF_FFFF;
    #1;
    sb_push("wrap_pre", SEL_CNT, 32'hFFFF_FFFF);
    sample();
    RA1 = 5'd10;
    drive(2'b10, 32'h0, 32'h2, 5'd10);
    tick();
    sb_push("wrap_cnt", SEL_CNT, 32'h0);
    sb_push("wrap_r10", SEL_RD1, 32'h2);
    sample();

    #2;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
